// File: rtl/fft_pkg.sv
// fft_pkg: shared constants and helpers for the 128-point SDF FFT control path
package fft_pkg;
  localparam int NFFT = 128;
  localparam int NSTAGES = $clog2(NFFT);
  localparam int ADDR_W = $clog2(NFFT/2);
  typedef logic [ADDR_W-1:0] tw_addr_t;
  function automatic int stage_len(input int s, input int n = NFFT);
    return n >> s;
  endfunction
endpackage

// File: rtl/sdf_stage_counter.sv
// sdf_stage_counter: per-stage sample counter driving butterfly enable and twiddle address
module sdf_stage_counter #(
  parameter int NFFT = fft_pkg::NFFT,
  parameter int STAGE = 0
)(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      valid,
  output logic                      bf_en,
  output logic [$clog2(NFFT/2)-1:0] tw_addr
);
  localparam int ADDR_W = $clog2(NFFT/2);
  localparam int L = fft_pkg::stage_len(STAGE, NFFT);
  localparam int CW = $clog2(L);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    if (rst || flush) cnt <= '0;
    else if (valid) cnt <= cnt + CW'(1);
  assign bf_en = cnt[CW-1];
  // low counter bits scaled by 2^STAGE fill the address exactly; last stage has none
  if (CW > 1) begin : g_addr
    assign tw_addr = bf_en ? '0 : ADDR_W'(ADDR_W'(cnt[CW-2:0]) << STAGE);
  end else begin : g_zero
    assign tw_addr = '0;
  end
endmodule

// File: rtl/sdf_twiddle_sequencer.sv
// sdf_twiddle_sequencer: SDF FFT stage sequencing, frame tracking; TW_ADDR_REG_EN registers bf_en/tw_addr
module sdf_twiddle_sequencer #(
  parameter int NFFT = fft_pkg::NFFT,
  parameter int NSTAGES = $clog2(NFFT),
  parameter int ADDR_W = $clog2(NFFT/2),
  parameter int FCNT_W = 16
)(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NSTAGES-1:0]        stage_valid,
  output logic [NSTAGES-1:0]        bf_en,
  output logic [NSTAGES*ADDR_W-1:0] tw_addr,
  output logic                      frame_done,
  output logic [FCNT_W-1:0]         frame_cnt
);
  logic [NSTAGES-1:0] bf_c;
  logic [NSTAGES*ADDR_W-1:0] tw_c;
  logic [NSTAGES-1:0] ocnt;
  logic last_wrap;
  for (genvar s = 0; s < NSTAGES; s++) begin : g_stage
    sdf_stage_counter #(.NFFT(NFFT), .STAGE(s)) u_cnt (
      .clk(clk),
      .rst(rst),
      .flush(flush),
      .valid(stage_valid[s]),
      .bf_en(bf_c[s]),
      .tw_addr(tw_c[s*ADDR_W +: ADDR_W])
    );
  end
  assign last_wrap = stage_valid[NSTAGES-1] && (&ocnt);
  always_ff @(posedge clk)
    if (rst) begin
      ocnt <= '0;
      frame_done <= 1'b0;
      frame_cnt <= '0;
    end else if (flush) begin
      ocnt <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= last_wrap;
      if (last_wrap) frame_cnt <= frame_cnt + FCNT_W'(1);
      if (stage_valid[NSTAGES-1]) ocnt <= ocnt + NSTAGES'(1);
    end
`ifdef TW_ADDR_REG_EN
  always_ff @(posedge clk)
    if (rst) begin
      bf_en <= '0;
      tw_addr <= '0;
    end else begin
      bf_en <= bf_c;
      tw_addr <= tw_c;
    end
`else
  assign bf_en = bf_c;
  assign tw_addr = tw_c;
`endif
endmodule

// File: tb/tb_sdf_twiddle_sequencer.sv
// tb_sdf_twiddle_sequencer: directed bench with a per-cycle reference model plus hand-computed vector table
module tb_sdf_twiddle_sequencer;
  localparam int NS = 7;
  localparam int AW = 6;
`ifdef TW_ADDR_REG_EN
  localparam bit LAT = 1'b1;
`else
  localparam bit LAT = 1'b0;
`endif
  typedef struct {int ph; int s; int k; bit bf; int ad;} vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic [NS-1:0] stage_valid = '0;
  logic [NS-1:0] bf_en;
  logic [NS*AW-1:0] tw_addr;
  logic frame_done;
  logic [15:0] frame_cnt;
  int errors = 0;
  int checks = 0;
  int k[NS];
  int pk[NS];
  bit pv[NS];
  bit eb_p[NS];
  int ea_p[NS];
  int oc = 0;
  int fc_e = 0;
  bit fd_e = 1'b0;
  int fd_pulses = 0;
  bit obs_bf[NS][256];
  int obs_ad[NS][256];
  vec_t tbl[24];

  sdf_twiddle_sequencer #(.NFFT(128), .FCNT_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .stage_valid(stage_valid),
    .bf_en(bf_en),
    .tw_addr(tw_addr),
    .frame_done(frame_done),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic [NS-1:0] v, input bit fl, input bit r, input bit ck);
    int len, h, p, ea, aa;
    bit eb, ab;
    @(negedge clk);
    stage_valid = v;
    flush = fl;
    rst = r;
    #1;
    if (frame_done === 1'b1) fd_pulses++;
    if (ck) begin
      check("frame_done", {31'd0, frame_done}, {31'd0, fd_e});
      check("frame_cnt", {16'd0, frame_cnt}, fc_e);
    end
    for (int s = 0; s < NS; s++) begin
      len = 128 >> s;
      h = len / 2;
      p = k[s] % len;
      eb = (p >= h);
      ea = eb ? 0 : ((p % h) * (1 << s)) % 64;
      ab = bf_en[s];
      aa = int'(tw_addr[s*AW +: AW]);
      if (ck) begin
        check($sformatf("bf_en[%0d] k=%0d", s, k[s]), {31'd0, ab}, LAT ? {31'd0, eb_p[s]} : {31'd0, eb});
        check($sformatf("tw_addr[%0d] k=%0d", s, k[s]), aa, LAT ? ea_p[s] : ea);
      end
      if (LAT ? pv[s] : (v[s] && !r)) begin
        if ((LAT ? pk[s] : k[s]) < 256) begin
          obs_bf[s][LAT ? pk[s] : k[s]] = ab;
          obs_ad[s][LAT ? pk[s] : k[s]] = aa;
        end
      end
      pv[s] = v[s] && !r;
      pk[s] = k[s];
      eb_p[s] = r ? 1'b0 : eb;
      ea_p[s] = r ? 0 : ea;
      k[s] = (r || fl) ? 0 : k[s] + int'(v[s]);
    end
    if (r) begin
      oc = 0; fd_e = 1'b0; fc_e = 0;
    end else if (fl) begin
      oc = 0; fd_e = 1'b0;
    end else begin
      fd_e = v[NS-1] && (oc == 127);
      if (fd_e) fc_e = (fc_e + 1) % 65536;
      if (v[NS-1]) oc = (oc + 1) % 128;
    end
  endtask

  task automatic check_table(input int ph);
    for (int i = 0; i < 24; i++)
      if (tbl[i].ph == ph) begin
        check($sformatf("tbl s%0d k%0d bf", tbl[i].s, tbl[i].k), {31'd0, obs_bf[tbl[i].s][tbl[i].k]}, {31'd0, tbl[i].bf});
        check($sformatf("tbl s%0d k%0d addr", tbl[i].s, tbl[i].k), obs_ad[tbl[i].s][tbl[i].k], tbl[i].ad);
      end
  endtask

  initial begin
    tbl = '{
      '{0,0,0,0,0}, '{0,0,1,0,1}, '{0,0,40,0,40}, '{0,0,63,0,63},
      '{0,0,64,1,0}, '{0,0,127,1,0}, '{0,0,128,0,0}, '{0,0,191,0,63},
      '{0,1,1,0,2}, '{0,1,31,0,62}, '{0,1,32,1,0}, '{0,1,65,0,2},
      '{0,2,5,0,20}, '{0,2,16,1,0}, '{0,2,33,0,4},
      '{0,5,1,0,32}, '{0,5,2,1,0},
      '{0,6,0,0,0}, '{0,6,1,1,0}, '{0,6,255,1,0},
      '{1,2,0,0,0}, '{1,2,1,0,4}, '{1,2,5,0,20}, '{1,2,15,0,60}
    };
    for (int s = 0; s < NS; s++) begin
      k[s] = 0; pk[s] = 0; pv[s] = 1'b0; eb_p[s] = 1'b0; ea_p[s] = 0;
      for (int j = 0; j < 256; j++) begin
        obs_bf[s][j] = 1'b0;
        obs_ad[s][j] = -1;
      end
    end
    // reset held with all valids asserted, then idle check of reset state
    step('1, 1'b0, 1'b1, 1'b0);
    step('1, 1'b0, 1'b1, 1'b0);
    step('0, 1'b0, 1'b0, 1'b1);
    // continuous valid on every stage: two full frames at the last stage
    for (int i = 0; i < 256; i++) step('1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step('0, 1'b0, 1'b0, 1'b1);
    check("frame_done pulses", fd_pulses, 2);
    check("frame_cnt after 256", {16'd0, frame_cnt}, 2);
    check_table(0);
    // stage 2 with 1-on/2-off gaps after a flush
    for (int j = 0; j < 256; j++) obs_ad[2][j] = -1;
    step('0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 48; i++) step((i % 3 == 0) ? 7'b0000100 : 7'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) step('0, 1'b0, 1'b0, 1'b1);
    check_table(1);
    // flush on stage 0 sample 40 drops that sample and keeps frame_cnt
    step('0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) step(7'b0000001, 1'b0, 1'b0, 1'b1);
    step(7'b0000001, 1'b1, 1'b0, 1'b1);
    step('0, 1'b0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b0, 1'b1);
    check("stage0 addr after flush", {26'd0, tw_addr[AW-1:0]}, 0);
    check("stage0 bf after flush", {31'd0, bf_en[0]}, 0);
    check("frame_cnt after flush", {16'd0, frame_cnt}, 2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
